// File: rtl/iter_muldiv_if.sv
// Request/response bundle between the execute stage (master) and iter_muldiv (slave).
interface iter_muldiv_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (output flush, in_valid, op, a, b, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  flush, in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit with sign fix-up.
// Define MULDIV_FAST_MUL_EN to give ops 0-2 a single-cycle multiplier.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  iter_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_MOD, OP_MODU, OP_RSVD
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_in;
  logic               neg_a_q, neg_b_q;
  logic [2*WIDTH-1:0] acc_q;       // {partial product} or {remainder, quotient}
  logic [WIDTH-1:0]   dsr_q;       // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept, signed_op, is_div, div_zero, short_path, is_mul_q;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, short_result, fix_result, quot, rem;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] acc_next, prod_fix;

  assign op_in         = op_t'(bus.op);
  assign accept        = bus.in_valid && (state_q == IDLE) && !bus.flush;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign is_mul_q      = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    signed_op    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_MOD);
    is_div       = (op_in == OP_DIV) || (op_in == OP_DIVU) || (op_in == OP_MOD) || (op_in == OP_MODU);
    div_zero     = is_div && (bus.b == '0);
    neg_a        = signed_op && bus.a[WIDTH-1];
    neg_b        = signed_op && bus.b[WIDTH-1];
    abs_a        = neg_a ? -bus.a : bus.a;
    abs_b        = neg_b ? -bus.b : bus.b;
    short_path   = (op_in == OP_RSVD) || div_zero;
    short_result = '0;
    if (div_zero)
      short_result = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : bus.a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_s, prod_u, fast_mul;
  logic               fast_op;

  // Sign-extending to 2*WIDTH makes the truncated product the exact signed product.
  assign prod_s  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_u  = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  assign fast_op = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHU);
  assign fast_mul = (op_in == OP_MULH) ? prod_s : prod_u;
`endif

  // One shift-add or one restoring-subtract step per RUN cycle.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dsr_q};
    acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
    if (is_mul_q)
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_fix   = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot       = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem        = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_result = '0;
    case (op_q)
      OP_MUL:          fix_result = acc_q[WIDTH-1:0];
      OP_MULH:         fix_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_MULHU:        fix_result = acc_q[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: fix_result = quot;
      OP_MOD, OP_MODU: fix_result = rem;
      OP_RSVD:         fix_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
        state_d = (short_path || fast_op) ? DONE : RUN;
`else
        state_d = short_path ? DONE : RUN;
`endif
      end
      RUN:  if (cnt_q == CW'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      acc_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      acc_q   <= {{WIDTH{1'b0}}, abs_a};
      dsr_q   <= abs_b;
      cnt_q   <= short_path ? '0 : CW'(WIDTH);
      if (short_path) result_q <= short_result;
`ifdef MULDIV_FAST_MUL_EN
      if (fast_op) begin
        cnt_q    <= '0;
        result_q <= (op_in == OP_MUL) ? fast_mul[WIDTH-1:0] : fast_mul[2*WIDTH-1:WIDTH];
      end
`endif
    end else if (state_q == RUN) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CW'(1);
    end else if (state_q == FIX) begin
      result_q <= fix_result;
    end
  end
endmodule
